en_window_serializer: RTL

//  Upstream driver for the en/in gated-capture stage. On a start request it waits
//  a programmable delay, then opens an enable window of exactly DATA_W cycles.

---
 rtl/en_window_serializer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/en_window_serializer.sv
// en_window_serializer: after a start request and a programmable delay, opens
// an enable window of exactly DATA_W cycles and shifts a captured word out LSB first.
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous reset, active-high
//   start     : request, sampled only when idle
//   abort     : cancels an operation in the delay or shift phase
//   data_in   : word to serialize, captured on the accepting edge
//   delay_cfg : cycles to wait before the window, captured with data_in
//   busy      : operation in flight (delay or shift phase)
//   en        : enable window to the downstream stage
//   ser_out   : serialized data, 0 whenever en is 0
//   done      : one-cycle pulse in the cycle after the last window cycle
module en_window_serializer #(
    parameter int DATA_W  = 8,
    parameter int DELAY_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [DELAY_W-1:0] delay_cfg,
    output logic               busy,
    output logic               en,
    output logic               ser_out,
    output logic               done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0]   bcnt_q, bcnt_d;
    logic               busy_q, busy_d;
    logic               en_q, en_d;
    logic               ser_q, ser_d;
    logic               done_q, done_d;

    // bcnt holds the number of window cycles already presented on the
    // outputs once the next edge lands; the window closes when it hits DATA_W.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dcnt_d  = dcnt_q;
        bcnt_d  = bcnt_q;
        ser_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // abort outranks start even while idle
                if (start && !abort) begin
                    if (delay_cfg == '0) begin
                        state_d = S_SHIFT;
                        ser_d   = data_in[0];
                        shreg_d = data_in >> 1;
                        bcnt_d  = CNT_W'(1);
                        dcnt_d  = '0;
                    end else begin
                        state_d = S_DELAY;
                        shreg_d = data_in;
                        dcnt_d  = delay_cfg;
                        bcnt_d  = '0;
                    end
                end
            end

            S_DELAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                    shreg_d = '0;
                    dcnt_d  = '0;
                    bcnt_d  = '0;
                end else if (dcnt_q == DELAY_W'(1)) begin
                    state_d = S_SHIFT;
                    ser_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    dcnt_d  = '0;
                    bcnt_d  = CNT_W'(1);
                end else begin
                    dcnt_d  = dcnt_q - DELAY_W'(1);
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    shreg_d = '0;
                    bcnt_d  = '0;
                end else if (bcnt_q == CNT_W'(DATA_W)) begin
                    state_d = S_IDLE;
                    shreg_d = '0;
                    bcnt_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    ser_d   = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    bcnt_d  = bcnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                dcnt_d  = '0;
                bcnt_d  = '0;
            end
        endcase

        // outputs are registered views of the next state
        busy_d = (state_d != S_IDLE);
        en_d   = (state_d == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            ser_q   <= ser_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign en      = en_q;
    assign ser_out = ser_q;
    assign done    = done_q;

endmodule
